fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
// Owns the program counter, three saved-PC registers and the run/done handshake for the core.
// Consumes the jump and save strobes produced by Ctrl each cycle (JumpEqual, JumpNotEqual, OffsetEn, PCRegSelect, Ack).
// Sequences program start, instruction fetch, jumps and program completion.
// Also counts retired instructions and aborts runaway programs with a watchdog.
// PARAMETERS
// PC_W        10     program counter width; instruction ROM depth = 2**PC_W
// PROG_BASE0  0      start address for ProgSel=0
// PROG_BASE1  256    start address for ProgSel=1
// PROG_BASE2  512    start address for ProgSel=2 (ProgSel=3 also uses PROG_BASE2)
// SPC_OFFSET  2      extra offset added by spc when OffsetEn=1
// MAX_INST    60000  watchdog limit on retired instructions per run
// PORTS
// Clk           in   1     system clock, rising edge
// Reset         in   1     synchronous, active-high
// Start         in   1     level request to run the program selected by ProgSel
// ProgSel       in   2     program select, sampled in IDLE when Start=1
// JumpEqual     in   1     from Ctrl: je instruction
// JumpNotEqual  in   1     from Ctrl: jne instruction
// OffsetEn      in   1     from Ctrl: spc adds SPC_OFFSET
// PCRegSelect   in   2     from Ctrl: 0=none, 1..3 selects PCreg1..PCreg3
// Ack           in   1     from Ctrl: current instruction is the halt (all ones)
// Equal         in   1     ALU equality flag for the current instruction
// ProgCtr       out  PC_W  instruction ROM address
// InstValid     out  1     current instruction commits; gates RegWrEn/MemWrEn in top_level
// Done          out  1     program finished; high in DONE only
// Timeout       out  1     last run ended by watchdog; sticky until next LOAD
// InstCount     out  16    instructions retired in current/last run
// BEHAVIOUR
// - Reset (at any point, including mid-run) takes effect at the next clock edge.
//   - state=IDLE, ProgCtr=0, PCreg1..3=0, Done=0, Timeout=0, InstCount=0, InstValid=0.
// - FSM states:
//   - IDLE -> LOAD when Start=1.
//   - LOAD (1 cycle): ProgCtr<=base selected by ProgSel, PCreg1..3<=0, InstCount<=0, Timeout<=0; -> RUN.
//   - RUN: InstValid=1 combinationally in RUN only; one instruction per cycle. Start is ignored in RUN.
//   - RUN -> DONE on Ack=1, or on watchdog.
//   - DONE: Done=1, ProgCtr holds. -> IDLE when Start=0. Start held high keeps DONE (no auto-restart).
// - Next PC in RUN, priority order:
//   - Ack=1: PC holds.
//   - Jump taken (JumpEqual&Equal | JumpNotEqual&~Equal, and PCRegSelect!=0): PC<=PCreg[PCRegSelect].
//   - Otherwise: PC<=PC+1, modulo 2**PC_W (wraps from all-ones to 0).
//   - A jump strobe with PCRegSelect=0 is treated as not taken.
// - spc (PCRegSelect!=0, JumpEqual=JumpNotEqual=0, Ack=0):
//   - PCreg[sel] <= PC+1+(OffsetEn ? SPC_OFFSET : 0), modulo 2**PC_W.
//   - PC still advances by 1.
//   - A jump never writes PCregs; saved values are readable by the very next instruction.
// - JumpEqual and JumpNotEqual both high is illegal input; treat it as JumpEqual only.
// - InstCount:
//   - +1 on every RUN cycle, including the Ack cycle.
//   - Saturates at 16'hFFFF.
//   - Holds in DONE/IDLE; cleared only in LOAD.
// - Watchdog: in a RUN cycle where InstCount==MAX_INST-1 and Ack=0:
//   - InstCount<=MAX_INST, Timeout<=1, state<=DONE, PC holds.
//   - If Ack=1 in that same cycle, Ack wins and Timeout stays 0.
// - Latency: Start=1 sampled at edge N -> LOAD during cycle N+1 -> first instruction fetched at base in cycle N+2.
//   Ack at edge M -> Done=1 from cycle M+1.
// TESTING
// 1. Start=1, ProgSel=1, Ack after 5 instructions -> ProgCtr 256..260, Done=1, InstCount=5, Timeout=0.
// 2. spc sel=2 OffsetEn=1 at PC=10, later je sel=2 with Equal=1 -> PCreg2=13, PC jumps to 13.
//    Same jump with Equal=0 -> PC=prev+1.
// 3. jne sel=0, Equal=0 -> not taken, PC+1. spc at PC=1023 -> PCreg=0, PC wraps to 0.
// 4. MAX_INST=8, never Ack -> Done=1 and Timeout=1 after 8 RUN cycles, InstCount=8.
//    Next Start clears Timeout in LOAD.
// 5. Reset asserted mid-RUN at PC=300 -> next cycle IDLE, ProgCtr=0, InstCount=0, Done=0.
// 6. Start held high through DONE -> stays DONE. Start low -> IDLE. Start high -> LOAD, Start pulses during RUN ignored.

Source files
------------

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Owns the program counter, three saved-PC registers and the run/done
// handshake for the core. Each RUN cycle it consumes the jump/save strobes from
// Ctrl, commits one instruction and picks the next fetch address. It also counts
// retired instructions and aborts runaway programs with a watchdog.
//
// Ports
//   Clk           in   1     system clock, rising edge
//   Reset         in   1     synchronous, active-high
//   Start         in   1     level request to run the program chosen by ProgSel
//   ProgSel       in   2     program select, captured in IDLE when Start=1
//   JumpEqual     in   1     je instruction
//   JumpNotEqual  in   1     jne instruction
//   OffsetEn      in   1     spc adds SPC_OFFSET to the saved address
//   PCRegSelect   in   2     0=none, 1..3 selects saved-PC register 1..3
//   Ack           in   1     current instruction is the halt
//   Equal         in   1     ALU equality flag for the current instruction
//   ProgCtr       out  PC_W  instruction ROM address
//   InstValid     out  1     current instruction commits (high in RUN only)
//   Done          out  1     program finished (high in DONE only)
//   Timeout       out  1     last run was ended by the watchdog; sticky to LOAD
//   InstCount     out  16    instructions retired in the current/last run
// -----------------------------------------------------------------------------
module fetch_sequencer #(
  parameter int PC_W       = 10,
  parameter int PROG_BASE0 = 0,
  parameter int PROG_BASE1 = 256,
  parameter int PROG_BASE2 = 512,
  parameter int SPC_OFFSET = 2,
  parameter int MAX_INST   = 60000
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic [1:0]      ProgSel,
  input  logic            JumpEqual,
  input  logic            JumpNotEqual,
  input  logic            OffsetEn,
  input  logic [1:0]      PCRegSelect,
  input  logic            Ack,
  input  logic            Equal,
  output logic [PC_W-1:0] ProgCtr,
  output logic            InstValid,
  output logic            Done,
  output logic            Timeout,
  output logic [15:0]     InstCount
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [15:0] WD_LAST  = 16'(MAX_INST - 1);
  localparam logic [15:0] WD_LIMIT = 16'(MAX_INST);

  state_t          state;
  state_t          state_next;
  logic [1:0]      prog_sel_q;
  logic [PC_W-1:0] saved_pc [3];

  logic            jump_strobe;
  logic            jump_cond;
  logic            jump_taken;
  logic            watchdog;
  logic            spc;
  logic [PC_W-1:0] pc_plus1;
  logic [PC_W-1:0] spc_value;
  logic [PC_W-1:0] base_pc;
  logic [PC_W-1:0] jump_target;
  logic [15:0]     count_inc;

  // je wins when both jump strobes are (illegally) high.
  assign jump_strobe = JumpEqual | JumpNotEqual;
  assign jump_cond   = JumpEqual ? Equal : (JumpNotEqual & ~Equal);
  assign jump_taken  = jump_cond & (PCRegSelect != 2'd0);

  // Ack in the same cycle beats the watchdog, so Timeout stays clear.
  assign watchdog = (InstCount == WD_LAST) & ~Ack;

  // A watchdog cycle aborts the instruction, so a pending spc is dropped too.
  assign spc = ~jump_strobe & ~Ack & ~watchdog & (PCRegSelect != 2'd0);

  // PC arithmetic is naturally modulo 2**PC_W through the fixed result width.
  assign pc_plus1  = ProgCtr + PC_W'(1);
  assign spc_value = pc_plus1 + (OffsetEn ? PC_W'(SPC_OFFSET) : '0);
  assign count_inc = (InstCount == 16'hFFFF) ? InstCount : InstCount + 16'd1;

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    base_pc = PC_W'(PROG_BASE2);
    case (prog_sel_q)
      2'd0:    base_pc = PC_W'(PROG_BASE0);
      2'd1:    base_pc = PC_W'(PROG_BASE1);
      default: base_pc = PC_W'(PROG_BASE2);
    endcase
  end

  always_comb begin
    jump_target = '0;
    case (PCRegSelect)
      2'd1:    jump_target = saved_pc[0];
      2'd2:    jump_target = saved_pc[1];
      2'd3:    jump_target = saved_pc[2];
      default: jump_target = '0;
    endcase
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_next = state;
    InstValid  = 1'b0;
    Done       = 1'b0;
    case (state)
      S_IDLE: if (Start) state_next = S_LOAD;
      S_LOAD: state_next = S_RUN;
      S_RUN: begin
        InstValid = 1'b1;
        if (Ack || watchdog) state_next = S_DONE;
      end
      S_DONE: begin
        Done = 1'b1;
        // Start held high keeps DONE: a new run needs Start to drop first.
        if (!Start) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= S_IDLE;
      prog_sel_q <= 2'd0;
      ProgCtr    <= '0;
      InstCount  <= '0;
      Timeout    <= 1'b0;
      // NOTE: the saved-PC file is only three registers with a defined reset
      // value, so it is cleared here rather than treated as unreset storage.
      for (int i = 0; i < 3; i++) saved_pc[i] <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: if (Start) prog_sel_q <= ProgSel;
        S_LOAD: begin
          ProgCtr   <= base_pc;
          InstCount <= '0;
          Timeout   <= 1'b0;
          for (int i = 0; i < 3; i++) saved_pc[i] <= '0;
        end
        S_RUN: begin
          if (watchdog) begin
            InstCount <= WD_LIMIT;
            Timeout   <= 1'b1;
          end else begin
            InstCount <= count_inc;
            // Halt holds the PC; otherwise jump or fall through.
            if (!Ack) ProgCtr <= jump_taken ? jump_target : pc_plus1;
          end
          for (int i = 0; i < 3; i++) begin
            if (spc && (PCRegSelect == 2'(i + 1))) saved_pc[i] <= spc_value;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Drives fetch_sequencer with directed and random instruction streams and
// compares every cycle against a behavioural model of the run/fetch rules.
// A second instance with a tiny watchdog limit covers the timeout path.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

  localparam int PC_W     = 10;
  localparam int DEPTH    = 1 << PC_W;
  localparam int MAX_MAIN = 60000;
  localparam int MAX_WD   = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [1:0]      prog_sel;
  logic            je;
  logic            jne;
  logic            off;
  logic [1:0]      sel;
  logic            ack;
  logic            equal;

  logic [PC_W-1:0] pc;
  logic            valid;
  logic            done;
  logic            timeout;
  logic [15:0]     icount;

  logic [PC_W-1:0] wd_pc;
  logic            wd_valid;
  logic            wd_done;
  logic            wd_timeout;
  logic [15:0]     wd_icount;

  always #5 clk = ~clk;

  fetch_sequencer #(.MAX_INST(MAX_MAIN)) dut (
    .Clk(clk), .Reset(reset), .Start(start), .ProgSel(prog_sel),
    .JumpEqual(je), .JumpNotEqual(jne), .OffsetEn(off), .PCRegSelect(sel),
    .Ack(ack), .Equal(equal),
    .ProgCtr(pc), .InstValid(valid), .Done(done), .Timeout(timeout),
    .InstCount(icount)
  );

  fetch_sequencer #(.MAX_INST(MAX_WD)) dut_wd (
    .Clk(clk), .Reset(reset), .Start(start), .ProgSel(prog_sel),
    .JumpEqual(je), .JumpNotEqual(jne), .OffsetEn(off), .PCRegSelect(sel),
    .Ack(ack), .Equal(equal),
    .ProgCtr(wd_pc), .InstValid(wd_valid), .Done(wd_done), .Timeout(wd_timeout),
    .InstCount(wd_icount)
  );

  // Behavioural model of the main instance.
  typedef enum {M_IDLE, M_LOAD, M_RUN, M_DONE} mode_t;
  mode_t m_mode;
  int    m_pc;
  int    m_reg [4];
  int    m_cnt;
  bit    m_to;
  int    m_sel;

  int    pass_cnt  = 0;
  int    total_cnt = 0;
  string phase     = "reset";

  function automatic int base_of(int s);
    if (s == 0) return 0;
    if (s == 1) return 256;
    return 512;
  endfunction

  // Advance the model by one clock edge using the inputs as they stand now.
  task automatic model_update();
    int  nxt_cnt;
    bit  taken;
    nxt_cnt = (m_cnt == 65535) ? m_cnt : m_cnt + 1;
    if (reset) begin
      m_mode = M_IDLE; m_pc = 0; m_cnt = 0; m_to = 1'b0; m_sel = 0;
      for (int i = 0; i < 4; i++) m_reg[i] = 0;
    end else begin
      case (m_mode)
        M_IDLE: if (start) begin m_sel = int'(prog_sel); m_mode = M_LOAD; end
        M_LOAD: begin
          m_pc = base_of(m_sel); m_cnt = 0; m_to = 1'b0; m_mode = M_RUN;
          for (int i = 0; i < 4; i++) m_reg[i] = 0;
        end
        M_RUN: begin
          if (ack) begin
            m_cnt = nxt_cnt; m_mode = M_DONE;
          end else if (m_cnt == MAX_MAIN - 1) begin
            m_cnt = MAX_MAIN; m_to = 1'b1; m_mode = M_DONE;
          end else begin
            m_cnt = nxt_cnt;
            if (je || jne) begin
              taken = je ? equal : !equal;
              if (taken && sel != 0) m_pc = m_reg[sel];
              else m_pc = (m_pc + 1) % DEPTH;
            end else begin
              if (sel != 0) m_reg[sel] = (m_pc + 1 + (off ? 2 : 0)) % DEPTH;
              m_pc = (m_pc + 1) % DEPTH;
            end
          end
        end
        M_DONE: if (!start) m_mode = M_IDLE;
        default: m_mode = M_IDLE;
      endcase
    end
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s/%s: observed %0d expected %0d", phase, tag, obs, exp);
  endtask

  task automatic check_model();
    check("ProgCtr",   32'(pc),      32'(m_pc));
    check("InstValid", 32'(valid),   32'(m_mode == M_RUN));
    check("Done",      32'(done),    32'(m_mode == M_DONE));
    check("Timeout",   32'(timeout), 32'(m_to));
    check("InstCount", 32'(icount),  32'(m_cnt));
  endtask

  // One clock: model sees the pre-edge inputs, DUT is sampled 1ns after.
  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic clear_strobes();
    je = 1'b0; jne = 1'b0; off = 1'b0; sel = 2'd0; ack = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; prog_sel = 2'd0; equal = 1'b0;
    clear_strobes();
    m_mode = M_IDLE; m_pc = 0; m_cnt = 0; m_to = 1'b0; m_sel = 0;
    for (int i = 0; i < 4; i++) m_reg[i] = 0;
    #2;
    step();
    step();
    check("rst_pc", 32'(pc), 0);
    check("rst_done", 32'(done), 0);
    check("rst_count", 32'(icount), 0);
    reset = 1'b0;

    // Program 1, halt on the fifth instruction; Start stays high throughout.
    phase = "prog1";
    start = 1'b1; prog_sel = 2'd1;
    step();
    prog_sel = 2'd0;
    step();
    check("first_fetch", 32'(pc), 256);
    repeat (4) step();
    check("fifth_fetch", 32'(pc), 260);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("halt_done", 32'(done), 1);
    check("halt_count", 32'(icount), 5);
    check("halt_pc", 32'(pc), 260);
    check("halt_timeout", 32'(timeout), 0);
    repeat (3) step();
    check("start_held_done", 32'(done), 1);
    start = 1'b0;
    step();
    check("back_to_idle", 32'(done), 0);

    // spc with offset, then je/jne taken and not taken.
    phase = "jumps";
    start = 1'b1; prog_sel = 2'd0;
    step();
    start = 1'b0;
    step();
    repeat (10) step();
    check("at_ten", 32'(pc), 10);
    sel = 2'd2; off = 1'b1;
    step();
    clear_strobes();
    step();
    je = 1'b1; sel = 2'd2; equal = 1'b1;
    step();
    check("je_taken", 32'(pc), 13);
    equal = 1'b0;
    step();
    check("je_not_taken", 32'(pc), 14);
    je = 1'b0; jne = 1'b1; sel = 2'd0; equal = 1'b0;
    step();
    check("jne_sel0", 32'(pc), 15);
    clear_strobes();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("start_ignored_run", 32'(valid), 1);

    // Random instruction streams, including illegal je+jne and resets.
    phase = "random";
    repeat (300) begin
      je       = ($urandom_range(0, 3) == 0);
      jne      = ($urandom_range(0, 3) == 0);
      off      = 1'($urandom);
      sel      = 2'($urandom_range(0, 3));
      equal    = 1'($urandom);
      ack      = ($urandom_range(0, 29) == 0);
      start    = ($urandom_range(0, 3) != 0);
      prog_sel = 2'($urandom_range(0, 3));
      reset    = ($urandom_range(0, 99) == 0);
      step();
    end
    clear_strobes();
    start = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;

    // Walk program 2 up to the top of the ROM and wrap.
    phase = "wrap";
    start = 1'b1; prog_sel = 2'd2;
    step();
    start = 1'b0;
    step();
    repeat (511) step();
    check("at_top", 32'(pc), 1023);
    sel = 2'd1;
    step();
    check("wrap_pc", 32'(pc), 0);
    je = 1'b1; sel = 2'd1; equal = 1'b1;
    step();
    check("jump_wrapped_reg", 32'(pc), 0);
    clear_strobes();
    ack = 1'b1;
    step();
    ack = 1'b0;
    step();

    // Reset in the middle of a run.
    phase = "midreset";
    start = 1'b1; prog_sel = 2'd1;
    step();
    start = 1'b0;
    step();
    repeat (44) step();
    check("at_300", 32'(pc), 300);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_pc", 32'(pc), 0);
    check("mid_rst_count", 32'(icount), 0);
    check("mid_rst_valid", 32'(valid), 0);

    // Watchdog on the small-limit instance.
    phase = "watchdog";
    start = 1'b1; prog_sel = 2'd0;
    step();
    start = 1'b0;
    step();
    repeat (7) step();
    check("wd_not_early_done", 32'(wd_done), 0);
    check("wd_not_early_to", 32'(wd_timeout), 0);
    step();
    check("wd_done", 32'(wd_done), 1);
    check("wd_timeout", 32'(wd_timeout), 1);
    check("wd_count", 32'(wd_icount), 8);
    check("wd_pc_held", 32'(wd_pc), 7);
    check("wd_valid", 32'(wd_valid), 0);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("wd_sticky_idle", 32'(wd_timeout), 1);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("wd_cleared_load", 32'(wd_timeout), 0);
    check("wd_restart_count", 32'(wd_icount), 0);
    check("wd_restart_valid", 32'(wd_valid), 1);
    ack = 1'b1;
    step();
    ack = 1'b0;
    step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
